// File: rtl/boid_sched_pkg.sv
// rtl/boid_sched_pkg.sv - shared encodings and defaults for the boid frame scheduler
package boid_sched_pkg;

  // Shared with the BPU generate loop so both sides agree on the array size.
  localparam int MAX_BOIDS_DEFAULT = 64;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SWITCH = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] SRC_NONE   = 2'b00;
  localparam logic [1:0] SRC_CPU    = 2'b01;
  localparam logic [1:0] SRC_SCREEN = 2'b10;
  localparam logic [1:0] SRC_BOTH   = 2'b11;

endpackage

// File: rtl/rise_edge_detect.sv
// rtl/rise_edge_detect.sv - registered rising-edge detector for one refresh source
module rise_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) d_q <= 1'b0;
    else       d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/boid_frame_scheduler.sv
// rtl/boid_frame_scheduler.sv - frame sequencer: buffer switch, per-boid RAM writes, trigger arbitration
// Optional screen_end divider enabled by defining REFRESH_DIV_EN.
module boid_frame_scheduler
  import boid_sched_pkg::*;
#(
  parameter int MAX_BOIDS    = MAX_BOIDS_DEFAULT,
  parameter int IDX_W        = $clog2(MAX_BOIDS),
  parameter int PIXEL_ADDR_W = 19,
  parameter int REFRESH_DIV  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              src_sel,
  input  logic                    cpu_refresh,
  input  logic                    screen_end,
  input  logic [IDX_W:0]          boid_count,
  input  logic [PIXEL_ADDR_W-1:0] boid_addr_in,
  output logic [IDX_W-1:0]        boid_sel,
  output logic                    disp_we,
  output logic [PIXEL_ADDR_W-1:0] disp_addr,
  output logic                    buf_switch,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              overrun_cnt
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_BOIDS);

  logic cpu_rise;
  logic scr_rise;
  logic scr_trig;
  logic trigger;

  rise_edge_detect u_cpu_edge (
    .clk_i  (clock),
    .rst_i  (reset),
    .d_i    (cpu_refresh),
    .rise_o (cpu_rise)
  );

  rise_edge_detect u_scr_edge (
    .clk_i  (clock),
    .rst_i  (reset),
    .d_i    (screen_end),
    .rise_o (scr_rise)
  );

`ifdef REFRESH_DIV_EN
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Counts every screen edge regardless of busy/src_sel; only the wrapping edge triggers.
  assign div_d    = scr_rise ? ((div_q == DIV_LAST) ? '0 : div_q + 1'b1) : div_q;
  assign scr_trig = scr_rise & (div_q == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end
`else
  logic unused_refresh_div;
  assign unused_refresh_div = ^REFRESH_DIV;
  assign scr_trig = scr_rise;
`endif

  assign trigger = (cpu_rise & src_sel[0]) | (scr_trig & src_sel[1]);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             pend_q, pend_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [CNT_W-1:0] n_clamp;
  logic             last_sel;

  assign n_clamp  = (boid_count > MAX_N) ? MAX_N : boid_count;
  assign last_sel = ({1'b0, sel_q} == (n_q - 1'b1));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    n_d     = n_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_SWITCH;
          sel_d   = '0;
        end
      end
      ST_SWITCH: begin
        n_d     = n_clamp;
        sel_d   = '0;
        state_d = (n_clamp == '0) ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        if (last_sel) state_d = ST_DONE;
        else          sel_d   = sel_q + 1'b1;
      end
      ST_DONE: begin
        // A trigger landing here is served directly or refills the freed pending slot.
        if (pend_q) begin
          state_d = ST_SWITCH;
          sel_d   = '0;
          pend_d  = trigger;
        end else if (trigger) begin
          state_d = ST_SWITCH;
          sel_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (trigger && (state_q == ST_SWITCH || state_q == ST_WRITE)) begin
      if (!pend_q)              pend_d = 1'b1;
      else if (ovr_q != 8'hFF)  ovr_d  = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      n_q     <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      n_q     <= n_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign boid_sel    = sel_q;
  assign disp_we     = (state_q == ST_WRITE);
  assign buf_switch  = (state_q == ST_SWITCH);
  assign frame_done  = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign disp_addr   = boid_addr_in;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// tb/tb_boid_frame_scheduler.sv - directed vector bench for boid_frame_scheduler
module tb_boid_frame_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  src_sel = 2'b00;
  logic        cpu_refresh = 1'b0;
  logic        screen_end = 1'b0;
  logic [6:0]  boid_count = 7'd0;
  logic [18:0] boid_addr_in;
  logic [5:0]  boid_sel;
  logic        disp_we;
  logic [18:0] disp_addr;
  logic        buf_switch;
  logic        busy;
  logic        frame_done;
  logic [7:0]  overrun_cnt;

  boid_frame_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .src_sel      (src_sel),
    .cpu_refresh  (cpu_refresh),
    .screen_end   (screen_end),
    .boid_count   (boid_count),
    .boid_addr_in (boid_addr_in),
    .boid_sel     (boid_sel),
    .disp_we      (disp_we),
    .disp_addr    (disp_addr),
    .buf_switch   (buf_switch),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [18:0] addr_of(input logic [5:0] s);
    return 19'h10000 + 19'(s) * 19'd640;
  endfunction

  // BPU mux stand-in: each boid index maps to a distinct address
  assign boid_addr_in = addr_of(boid_sel);

  int n_chk = 0;
  int n_fail = 0;
  int n_bs = 0;
  int n_we = 0;
  int n_fd = 0;

  always @(negedge clock) begin
    if (buf_switch) n_bs++;
    if (disp_we)    n_we++;
    if (frame_done) n_fd++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      if (frame_done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       cpu;
    logic [6:0] cnt;
    logic [3:0] flags;   // {buf_switch, disp_we, frame_done, busy}
    logic       chk_sel;
    logic [5:0] exp_sel;
  } vec_t;

  vec_t tbl[24];
  bit   ok;
  int   b_bs, b_we, b_fd;
  logic [63:0] exp_v;

  initial begin
    tbl[0]  = '{2'b01, 1'b0, 7'd4, 4'b0000, 1'b1, 6'd0};
    tbl[1]  = '{2'b01, 1'b1, 7'd4, 4'b1001, 1'b1, 6'd0};
    tbl[2]  = '{2'b01, 1'b1, 7'd4, 4'b0101, 1'b1, 6'd0};
    tbl[3]  = '{2'b01, 1'b1, 7'd4, 4'b0101, 1'b1, 6'd1};
    tbl[4]  = '{2'b01, 1'b1, 7'd4, 4'b0101, 1'b1, 6'd2};
    tbl[5]  = '{2'b01, 1'b1, 7'd4, 4'b0101, 1'b1, 6'd3};
    tbl[6]  = '{2'b01, 1'b0, 7'd4, 4'b0011, 1'b0, 6'd0};
    tbl[7]  = '{2'b01, 1'b0, 7'd4, 4'b0000, 1'b0, 6'd0};
    tbl[8]  = '{2'b01, 1'b1, 7'd0, 4'b1001, 1'b1, 6'd0};
    tbl[9]  = '{2'b01, 1'b0, 7'd0, 4'b0011, 1'b0, 6'd0};
    tbl[10] = '{2'b01, 1'b0, 7'd0, 4'b0000, 1'b0, 6'd0};
    tbl[11] = '{2'b01, 1'b1, 7'd1, 4'b1001, 1'b1, 6'd0};
    tbl[12] = '{2'b01, 1'b0, 7'd1, 4'b0101, 1'b1, 6'd0};
    tbl[13] = '{2'b01, 1'b0, 7'd1, 4'b0011, 1'b0, 6'd0};
    tbl[14] = '{2'b01, 1'b1, 7'd1, 4'b1001, 1'b1, 6'd0};
    tbl[15] = '{2'b01, 1'b0, 7'd1, 4'b0101, 1'b1, 6'd0};
    tbl[16] = '{2'b01, 1'b0, 7'd1, 4'b0011, 1'b0, 6'd0};
    tbl[17] = '{2'b01, 1'b0, 7'd1, 4'b0000, 1'b0, 6'd0};
    tbl[18] = '{2'b10, 1'b1, 7'd1, 4'b0000, 1'b0, 6'd0};
    tbl[19] = '{2'b01, 1'b1, 7'd1, 4'b0000, 1'b0, 6'd0};
    tbl[20] = '{2'b00, 1'b0, 7'd1, 4'b0000, 1'b0, 6'd0};
    tbl[21] = '{2'b00, 1'b1, 7'd1, 4'b0000, 1'b0, 6'd0};
    tbl[22] = '{2'b01, 1'b1, 7'd1, 4'b0000, 1'b0, 6'd0};
    tbl[23] = '{2'b01, 1'b0, 7'd1, 4'b0000, 1'b0, 6'd0};

    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", {boid_sel, disp_we, buf_switch, busy, frame_done, overrun_cnt}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      src_sel     = tbl[i].sel;
      cpu_refresh = tbl[i].cpu;
      boid_count  = tbl[i].cnt;
      @(posedge clock); #1;
      check($sformatf("vec%0d_flags", i), {buf_switch, disp_we, frame_done, busy}, tbl[i].flags);
      check($sformatf("vec%0d_overrun", i), overrun_cnt, 8'd0);
      if (tbl[i].chk_sel) begin
        check($sformatf("vec%0d_boid_sel", i), boid_sel, tbl[i].exp_sel);
        check($sformatf("vec%0d_disp_addr", i), disp_addr, addr_of(tbl[i].exp_sel));
      end
    end

    // Both sources rise together, then two more triggers mid-frame
    @(negedge clock);
    b_bs = n_bs; b_we = n_we; b_fd = n_fd;
    src_sel = 2'b11; boid_count = 7'd64;
    cpu_refresh = 1'b1; screen_end = 1'b1;
    repeat (10) @(negedge clock);
    cpu_refresh = 1'b0; screen_end = 1'b0;
    @(negedge clock); cpu_refresh = 1'b1;
    @(negedge clock); cpu_refresh = 1'b0;
    @(negedge clock); cpu_refresh = 1'b1;
    @(negedge clock); cpu_refresh = 1'b0;
    wait_fd(ok);
    check("pend_fd1_seen", ok, 1'b1);
    @(posedge clock); #1;
    check("pend_b2b_switch", {buf_switch, busy}, 2'b11);
    wait_fd(ok);
    check("pend_fd2_seen", ok, 1'b1);
    @(posedge clock); #1;
    check("pend_idle_after", busy, 1'b0);
    check("pend_overrun", overrun_cnt, 8'd1);
    check("pend_frames", n_bs - b_bs, 2);
    check("pend_done_pulses", n_fd - b_fd, 2);
    check("pend_we_cycles", n_we - b_we, 128);

    // Clamp: 100 requested, 64 written
    @(negedge clock);
    b_we = n_we; b_fd = n_fd;
    src_sel = 2'b01; boid_count = 7'd100; cpu_refresh = 1'b1;
    @(negedge clock); cpu_refresh = 1'b0;
    wait_fd(ok);
    check("clamp_fd_seen", ok, 1'b1);
    @(posedge clock); #1;
    check("clamp_we_cycles", n_we - b_we, 64);
    check("clamp_done_pulses", n_fd - b_fd, 1);

    // Reset in the middle of a frame
    @(negedge clock);
    boid_count = 7'd20; cpu_refresh = 1'b1;
    @(negedge clock); cpu_refresh = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (disp_we && boid_sel == 6'd10) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_reached_sel10", ok, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_async_outputs", {boid_sel, disp_we, buf_switch, busy, frame_done, overrun_cnt}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    b_we = n_we; b_fd = n_fd; b_bs = n_bs;
    repeat (30) @(posedge clock);
    #1;
    check("rst_no_we", n_we - b_we, 0);
    check("rst_no_done", n_fd - b_fd, 0);
    check("rst_no_switch", n_bs - b_bs, 0);
    @(negedge clock); cpu_refresh = 1'b1;
    @(posedge clock); #1;
    check("rst_new_trigger", buf_switch, 1'b1);
    @(negedge clock); cpu_refresh = 1'b0;
    wait_fd(ok);
    check("rst_new_frame_done", ok, 1'b1);

    // Screen_end pulses, divided or not
    @(negedge clock);
    b_bs = n_bs;
    src_sel = 2'b10; boid_count = 7'd1;
    for (int p = 1; p <= 32; p++) begin
      @(negedge clock); screen_end = 1'b1;
      @(negedge clock); screen_end = 1'b0;
      repeat (5) @(negedge clock);
`ifdef REFRESH_DIV_EN
      exp_v = (p >= 32) ? 64'd2 : (p >= 16) ? 64'd1 : 64'd0;
`else
      exp_v = 64'(p);
`endif
      if (p == 15 || p == 16 || p == 32)
        check($sformatf("div_frames_after_%0d", p), 64'(n_bs - b_bs), exp_v);
    end
    check("div_overrun", overrun_cnt, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/boid_frame_scheduler.md
# boid_frame_scheduler

Sequences each boid-display frame update: on a refresh trigger it pulses the display-buffer switch, then steps a boid index through all active BPUs, asserting write enable into the boid display RAM once per boid. It also arbitrates the two refresh sources, the CPU refresh register and the VGA end-of-screen strobe, and queues one trigger that arrives while a frame is in flight. It sits between the CPU register taps, the BPU output mux and the resettable display RAM.

## Interface
- MAX_BOIDS, 64: number of BPU instances; must be a power of two.
- IDX_W, $clog2(MAX_BOIDS): width of the boid index.
- PIXEL_ADDR_W, 19: display RAM address width.
- REFRESH_DIV, 16: screen_end divisor. Only used with REFRESH_DIV_EN.

Ports:
- clock  in  1: system clock. All logic is synchronous to it.
- reset  in  1: asynchronous, active-high reset.
- src_sel  in  2: refresh source. 00 = none, 01 = CPU only, 10 = screen_end only, 11 = both.
- cpu_refresh  in  1: level from the CPU refresh register (nonzero = high).
- screen_end  in  1: VGA end-of-frame level, already synchronous to clock.
- boid_count  in  IDX_W+1: number of active boids.
- boid_addr_in  in  PIXEL_ADDR_W: address returned by the BPU mux for boid_sel.
- boid_sel  out  IDX_W: BPU index to read.
- disp_we  out  1: display RAM write enable.
- disp_addr  out  PIXEL_ADDR_W: display RAM write address (passthrough of boid_addr_in).
- buf_switch  out  1: one-cycle pulse that switches to a cleared buffer.
- busy  out  1: high from SWITCH through DONE inclusive.
- frame_done  out  1: one-cycle pulse at the end of a frame.
- overrun_cnt  out  8: saturating count of dropped triggers.

## Operation
- **Trigger detection.** Each enabled source is rising-edge detected against a registered copy of itself.
  - trigger = (cpu edge & src_sel[0]) | (screen edge & src_sel[1]).
  - Simultaneous edges on both sources count as one trigger.
- **States:** IDLE, SWITCH, WRITE, DONE.
- **IDLE.** On a trigger, go to SWITCH.
- **SWITCH.**
  - buf_switch = 1 for this one cycle.
  - Latch n = min(boid_count, MAX_BOIDS) and clear boid_sel to 0.
  - If n == 0, go to DONE. Otherwise go to WRITE.
- **WRITE.**
  - disp_we = 1 every cycle.
  - boid_sel increments each cycle. When boid_sel == n-1, go to DONE.
- **DONE.**
  - frame_done = 1 for this one cycle.
  - If pending is set, clear it and go to SWITCH. Otherwise go to IDLE.
- **Pending flag.**
  - A trigger seen while busy sets pending. The flag is one deep.
  - A trigger seen while pending is already set increments overrun_cnt, which saturates at 255.
  - A trigger in the same cycle as DONE→IDLE is serviced (goes to SWITCH next) and is not counted as an overrun.
- **Write address.** disp_addr = boid_addr_in, combinational.
  - boid_sel is registered, so the BPU mux address settles within the same cycle as disp_we.
- **Mid-frame changes.** A src_sel change mid-frame affects only future triggers.

## Timing
- **Reset values:** state = IDLE, boid_sel = 0, disp_we = 0, buf_switch = 0, busy = 0, frame_done = 0, overrun_cnt = 0, pending = 0, edge registers = 0.
- **Reset mid-frame:** the frame aborts immediately. No further disp_we is issued, and no frame_done is issued for the aborted frame.
- **Frame timeline** (trigger level sampled high at edge T, previously low):
  - buf_switch is high during cycle T+1.
  - disp_we is high during cycles T+2 … T+1+n, with boid_sel = 0 … n-1.
  - frame_done is high during cycle T+2+n.
- **Frame length:** n+2 cycles of busy. Back-to-back frames from pending have no IDLE gap.
- **Trigger rate:** a source level held high produces exactly one trigger.

## Configuration
- **REFRESH_DIV_EN defined:**
  - A counter of width $clog2(REFRESH_DIV) counts screen_end edges.
  - Only the edge on which the counter wraps to 0 becomes a screen trigger.
  - The counter resets to 0, so the first trigger occurs on the REFRESH_DIV-th edge.
  - The counter advances even while busy.
  - CPU triggers are never divided.
- **REFRESH_DIV_EN undefined:** every screen_end edge is a trigger, and REFRESH_DIV is ignored.

## Structure
- **Shared package / include `boid_sched_pkg`:**
  - State encodings (IDLE = 0, SWITCH = 1, WRITE = 2, DONE = 3).
  - src_sel encodings.
  - MAX_BOIDS default, shared with the BPU generate loop.
- **Sub-module `rise_edge_detect`:** one register plus AND-NOT, instantiated once per source.

## Test plan
- **Single CPU frame.** src_sel = 01, boid_count = 4, cpu_refresh rises at T → buf_switch at T+1; disp_we at T+2..T+5 with boid_sel 0,1,2,3; disp_addr tracks boid_addr_in; frame_done at T+6.
- **Zero boids.** boid_count = 0 → buf_switch, then frame_done on the next cycle, with disp_we never asserted.
- **Simultaneous sources, then pending, then overrun.**
  - src_sel = 11 with both sources rising together, n = 64 → exactly one frame.
  - Two more triggers during WRITE → second frame starts the cycle after frame_done, and overrun_cnt = 1.
- **Reset mid-frame.** Assert reset at boid_sel = 10 → all outputs 0 asynchronously; after release, no frame_done and no disp_we until a new trigger.
- **Divider (REFRESH_DIV_EN, REFRESH_DIV = 16).** 32 screen_end pulses with src_sel = 10 → exactly 2 frames, beginning after pulses 16 and 32. Without the macro → 32 frames.
- **Clamp.** boid_count = 100 with MAX_BOIDS = 64 → exactly 64 disp_we cycles.
